// File: rtl/gnn_phase_scheduler_if.sv
// Signal bundle between a frame requester (master) and the phase scheduler (slave).
// It also carries the engine-side operand select and the completion pulses.
interface gnn_phase_scheduler_if #(
  parameter int NUM_NODES = 4,
  parameter int DROP_W    = 8
) ();
  localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  logic                 in_ready;
  logic [NUM_NODES-1:0] node_mask;
  logic                 stall;
  logic [NODE_W-1:0]    eng_node;
  logic [2:0]           eng_state;
  logic                 eng_valid;
  logic [NUM_NODES-1:0] out_ready;
  logic                 frame_done;
  logic                 busy;
  logic [DROP_W-1:0]    drop_cnt;

  modport master (
    output in_ready, node_mask, stall,
    input  eng_node, eng_state, eng_valid, out_ready, frame_done, busy, drop_cnt
  );

  modport slave (
    input  in_ready, node_mask, stall,
    output eng_node, eng_state, eng_valid, out_ready, frame_done, busy, drop_cnt
  );
endinterface

// File: rtl/gnn_phase_scheduler.sv
// Time-multiplexes one shared DNN engine across the active graph nodes of a frame.
// Scheduling is phase-major: every node finishes a phase before any node starts the next phase.
module gnn_phase_scheduler #(
  parameter int NUM_NODES = 4,
  parameter int DROP_W    = 8
) (
  input logic                    clk,
  input logic                    rst,
  gnn_phase_scheduler_if.slave   bus
);
  localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    Y4Y5_MUL  = 3'd1,
    Y6Y7_MUL  = 3'd2,
    FINAL_ADD = 3'd3,
    OUT_MUL   = 3'd4
  } phase_e;

  phase_e               state_q;
  logic [NODE_W-1:0]    node_q;
  logic [NUM_NODES-1:0] mask_q;
  logic [NUM_NODES-1:0] outReady_q;
  logic                 frameDone_q;
  logic                 inReadyPrev_q;
  logic [DROP_W-1:0]    dropCnt_q;

  logic [NODE_W-1:0]    firstNew_d;
  logic [NODE_W-1:0]    firstLatched_d;
  logic [NODE_W-1:0]    nextHigher_d;
  logic                 hasHigher_d;
  logic                 start;
  logic                 engValid;

  assign start    = bus.in_ready & ~inReadyPrev_q;
  assign engValid = (state_q != IDLE) & ~bus.stall;

  // Descending scan so the last hit is the lowest qualifying node.
  always_comb begin
    firstNew_d     = '0;
    firstLatched_d = '0;
    nextHigher_d   = '0;
    hasHigher_d    = 1'b0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (bus.node_mask[i]) firstNew_d = NODE_W'(i);
      if (mask_q[i]) firstLatched_d = NODE_W'(i);
      if (mask_q[i] && (i > int'(node_q))) begin
        nextHigher_d = NODE_W'(i);
        hasHigher_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      node_q        <= '0;
      mask_q        <= '0;
      outReady_q    <= '0;
      frameDone_q   <= 1'b0;
      inReadyPrev_q <= 1'b0;
      dropCnt_q     <= '0;
    end else begin
      inReadyPrev_q <= bus.in_ready;
      outReady_q    <= '0;
      frameDone_q   <= 1'b0;

      if (engValid) begin
        if (state_q == OUT_MUL) outReady_q <= NUM_NODES'(1) << node_q;
        if (hasHigher_d) begin
          node_q <= nextHigher_d;
        end else begin
          node_q <= firstLatched_d;
          unique case (state_q)
            Y4Y5_MUL:  state_q <= Y6Y7_MUL;
            Y6Y7_MUL:  state_q <= FINAL_ADD;
            FINAL_ADD: state_q <= OUT_MUL;
            OUT_MUL: begin
              state_q     <= IDLE;
              node_q      <= '0;
              frameDone_q <= 1'b1;
            end
            default:   state_q <= IDLE;
          endcase
        end
      end

      // An empty mask completes immediately without ever engaging the engine.
      if (start) begin
        if (state_q == IDLE) begin
          mask_q <= bus.node_mask;
          if (bus.node_mask == '0) begin
            frameDone_q <= 1'b1;
          end else begin
            state_q <= Y4Y5_MUL;
            node_q  <= firstNew_d;
          end
        end else if (dropCnt_q != {DROP_W{1'b1}}) begin
          dropCnt_q <= dropCnt_q + DROP_W'(1);
        end
      end
    end
  end

  assign bus.eng_state  = state_q;
  assign bus.eng_node   = node_q;
  assign bus.eng_valid  = engValid;
  assign bus.out_ready  = outReady_q;
  assign bus.frame_done = frameDone_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.drop_cnt   = dropCnt_q;
endmodule
